alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//   Width-parametrised, handshaked successor to the single-cycle ALU. Accepts one op per
//   cycle over valid/ready and returns result + o_flag/z_flag + tag from a registered
//   output stage with backpressure. Sits between the decode/issue stage and writeback.
//   An optional iterative multiplier stalls the pipe while it runs.
// PARAMETERS
//   WIDTH   32  operand/result width in bits (>=8, power of 2); shift amount = b[$clog2(WIDTH)-1:0]
//   TAG_W   4   width of the caller tag carried unchanged from input to output
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operand bundle valid
//   in_ready   out  1      block can accept a bundle this cycle
//   alu_cntr   in   4      opcode (table below)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   in_tag     in   TAG_W  caller tag
//   out_valid  out  1      result bundle valid
//   out_ready  in   1      consumer accepts result this cycle
//   alu_result out  WIDTH  result
//   o_flag     out  1      overflow flag
//   z_flag     out  1      alu_result == 0
//   out_tag    out  TAG_W  tag of the op that produced alu_result
// BEHAVIOUR
//   Reset: state=IDLE; out_valid=0, alu_result=0, o_flag=0, z_flag=0, out_tag=0, in_ready=0 while rst=1.
//   Ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA,
//     1000 SLT (signed, result 0/1), 1001 SLTU (unsigned, 0/1), 1010 MUL (MUL_ALU_EN only).
//     Any other opcode: alu_result=0, o_flag=0, z_flag=1 (single-cycle).
//   o_flag: ADD/SUB signed two's-complement overflow; MUL upper WIDTH bits of unsigned
//     2*WIDTH product nonzero; 0 for all other ops. Results wrap modulo 2^WIDTH.
//   Handshake: accept when in_valid && in_ready. Output transfers when out_valid && out_ready.
//     Output bundle holds stable while out_valid && !out_ready. in_valid must hold until accepted.
//   States: IDLE (no result held), HOLD (out_valid=1), BUSY (multiply running).
//     in_ready = (state==IDLE) || (state==HOLD && out_ready).
//     IDLE/HOLD + accept of single-cycle op -> HOLD; result registered, visible next cycle (latency 1).
//     HOLD + out_ready + no accept -> IDLE. Back-to-back accept+drain sustains 1 op/cycle.
//     IDLE/HOLD + accept of MUL -> BUSY; out_valid drops if its result drained that cycle.
//     BUSY: in_ready=0, out_valid=0; shift-add one bit/cycle, WIDTH cycles; then -> HOLD.
//       MUL latency = WIDTH+1 cycles accept-to-out_valid.
//   Tag: out_tag = in_tag of the accepted op, registered with the result.
//   Reset mid-operation: async clear to reset values; in-flight MUL and held result discarded.
//   in_valid while in_ready=0: ignored, no state change.
// CONFIGURATION
//   MUL_ALU_EN defined: opcode 1010 = iterative unsigned multiply (low WIDTH bits of a*b,
//     o_flag as above), BUSY state and counter present.
//   MUL_ALU_EN undefined: 1010 handled as an undefined opcode (result 0, z=1, o=0,
//     latency 1); no BUSY state, no multiplier datapath.
// TESTING
//   1) WIDTH=32, ADD a=7FFFFFFF b=1 tag=3, out_ready=1 -> next cycle result=80000000, o=1, z=0, tag=3.
//   2) SUB a=5 b=5 -> result=0, z=1, o=0; SRA a=80000000 b=0x21 -> result=C0000000 (shift uses b[4:0]=1).
//   3) Stream 8 ADDs on consecutive cycles with out_ready=1 -> 8 results on 8 consecutive cycles, tags in order.
//   4) out_ready=0 for 3 cycles after an op -> in_ready=0, result/tag stable; drop stall -> transfers once, next op accepted same cycle.
//   5) MUL_ALU_EN: MUL a=0x10000 b=0x10000 -> in_ready=0 for 32 cycles, result=0, o=1 at cycle 33; a=6 b=7 -> 42, o=0.
//   6) Assert rst mid-MUL (cycle 10) -> out_valid=0, outputs 0 immediately; after release next op completes normally.

Source files
------------

// File: rtl/alu_pipe.sv
// Handshaked, width-parametrised ALU with a registered output stage and backpressure.
// Define MUL_ALU_EN to add the iterative shift-add multiplier (opcode 1010, BUSY state).
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_cntr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             o_flag,
  output logic             z_flag,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSll  = 4'b0101;
  localparam logic [3:0] OpSrl  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpSlt  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1001;

`ifdef MUL_ALU_EN
  localparam logic [3:0] OpMul  = 4'b1010;
  typedef enum logic [1:0] {StIdle, StHold, StBusy} state_e;
`else
  typedef enum logic [1:0] {StIdle, StHold} state_e;
`endif

  state_e state_q, state_d;

  logic [WIDTH-1:0] res_q, res_d;
  logic             o_q, o_d;
  logic             z_q, z_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_o;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [ShW-1:0]   shamt;
  logic             accept;
  logic             is_mul;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[ShW-1:0];

  // Single-cycle datapath; MUL and undefined opcodes fall through to zero here.
  always_comb begin
    alu_res = '0;
    alu_o   = 1'b0;
    case (alu_cntr)
      OpAdd: begin
        alu_res = sum;
        alu_o   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_o   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpXor:  alu_res = a ^ b;
      OpSll:  alu_res = a << shamt;
      OpSrl:  alu_res = a >> shamt;
      OpSra:  alu_res = WIDTH'($signed(a) >>> shamt);
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: begin
        alu_res = '0;
        alu_o   = 1'b0;
      end
    endcase
  end

  assign in_ready  = !rst && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StHold);

`ifdef MUL_ALU_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [ShW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_step;

  assign is_mul    = (alu_cntr == OpMul);
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    o_d     = o_q;
    z_d     = z_q;
    tag_d   = tag_q;
`ifdef MUL_ALU_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      StIdle, StHold: begin
        if (accept) begin
          tag_d = in_tag;
          if (is_mul) begin
`ifdef MUL_ALU_EN
            state_d  = StBusy;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
`endif
          end else begin
            state_d = StHold;
            res_d   = alu_res;
            o_d     = alu_o;
            z_d     = (alu_res == '0);
          end
        end else if ((state_q == StHold) && out_ready) begin
          state_d = StIdle;
        end
      end
`ifdef MUL_ALU_EN
      StBusy: begin
        // One multiplier bit per cycle; the final step writes the output stage directly.
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == ShW'(WIDTH - 1)) begin
          state_d = StHold;
          res_d   = prod_step[WIDTH-1:0];
          o_d     = |prod_step[2*WIDTH-1:WIDTH];
          z_d     = (prod_step[WIDTH-1:0] == '0);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      res_q   <= '0;
      o_q     <= 1'b0;
      z_q     <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      o_q     <= o_d;
      z_q     <= z_d;
      tag_q   <= tag_d;
    end
  end

`ifdef MUL_ALU_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign alu_result = res_q;
  assign o_flag     = o_q;
  assign z_flag     = z_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32): vector table streamed back-to-back, then stall,
// reset and (with MUL_ALU_EN) multiplier sequences.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_cntr;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        o_flag;
  logic        z_flag;
  logic [3:0]  out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_cntr   (alu_cntr),
    .a          (a),
    .b          (b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .o_flag     (o_flag),
    .z_flag     (z_flag),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        o;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                       input logic [3:0] tag);
    in_valid = 1'b1;
    alu_cntr = op;
    a        = va;
    b        = vb;
    in_tag   = tag;
  endtask

  task automatic chk_out(input string name, input logic [31:0] res, input logic o,
                         input logic z, input logic [3:0] tag);
    chk({name, ".valid"}, {63'd0, out_valid}, 64'd1);
    chk({name, ".result"}, {32'd0, alu_result}, {32'd0, res});
    chk({name, ".o"}, {63'd0, o_flag}, {63'd0, o});
    chk({name, ".z"}, {63'd0, z_flag}, {63'd0, z});
    chk({name, ".tag"}, {60'd0, out_tag}, {60'd0, tag});
  endtask

  task automatic chk_reset(input string name);
    chk({name, ".out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({name, ".in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({name, ".result"}, {32'd0, alu_result}, 64'd0);
    chk({name, ".flags"}, {62'd0, o_flag, z_flag}, 64'd0);
    chk({name, ".tag"}, {60'd0, out_tag}, 64'd0);
  endtask

  initial begin
    int n;
    vecs.push_back('{4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 4'h3, 32'h8000_0000, 1'b1, 1'b0});
    vecs.push_back('{4'h1, 32'h0000_0005, 32'h0000_0005, 4'h1, 32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{4'h7, 32'h8000_0000, 32'h0000_0021, 4'h2, 32'hC000_0000, 1'b0, 1'b0});
    vecs.push_back('{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 4'h4, 32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{4'h1, 32'h8000_0000, 32'h0000_0001, 4'h5, 32'h7FFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{4'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'h6, 32'h00F0_00F0, 1'b0, 1'b0});
    vecs.push_back('{4'h3, 32'h1234_0000, 32'h0000_5678, 4'h7, 32'h1234_5678, 1'b0, 1'b0});
    vecs.push_back('{4'h4, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'h8, 32'hF0F0_0F0F, 1'b0, 1'b0});
    vecs.push_back('{4'h5, 32'h0000_0001, 32'h0000_001F, 4'h9, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{4'h6, 32'h8000_0000, 32'h0000_0004, 4'hA, 32'h0800_0000, 1'b0, 1'b0});
    vecs.push_back('{4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 4'hB, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 4'hC, 32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{4'hF, 32'h0000_0003, 32'h0000_0004, 4'hD, 32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{4'h0, 32'h0000_0003, 32'h0000_0004, 4'hE, 32'h0000_0007, 1'b0, 1'b0});
`ifndef MUL_ALU_EN
    vecs.push_back('{4'hA, 32'h0000_0006, 32'h0000_0007, 4'hF, 32'h0000_0000, 1'b0, 1'b1});
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_cntr = '0; a = '0; b = '0; in_tag = '0;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;
    #1;
    chk("idle.in_ready", {63'd0, in_ready}, 64'd1);
    chk("idle.out_valid", {63'd0, out_valid}, 64'd0);

    // Back-to-back stream: one accept and one drain every cycle.
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].tag);
      #1;
      chk($sformatf("v%0d.in_ready", i), {63'd0, in_ready}, 64'd1);
      tick();
      chk_out($sformatf("v%0d", i), vecs[i].res, vecs[i].o, vecs[i].z, vecs[i].tag);
    end
    in_valid = 1'b0;
    tick();
    chk("drain.out_valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: result held 3 cycles while a pending op waits.
    out_ready = 1'b0;
    drive(4'h0, 32'd1, 32'd2, 4'h5);
    tick();
    drive(4'h0, 32'd10, 32'd20, 4'h6);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", k), {63'd0, in_ready}, 64'd0);
      chk_out($sformatf("stall%0d", k), 32'd3, 1'b0, 1'b0, 4'h5);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("unstall.in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk_out("unstall.next", 32'd30, 1'b0, 1'b0, 4'h6);
    in_valid = 1'b0;
    tick();
    chk("unstall.drain", {63'd0, out_valid}, 64'd0);

    // Reset while a result is held.
    out_ready = 1'b0;
    drive(4'h0, 32'd9, 32'd9, 4'h7);
    tick();
    in_valid = 1'b0;
    chk_out("prehold", 32'd18, 1'b0, 1'b0, 4'h7);
    rst = 1'b1;
    #1;
    chk_reset("rst_hold");
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

`ifdef MUL_ALU_EN
    // MUL 0x10000 * 0x10000: low word zero, upper word nonzero.
    drive(4'hA, 32'h0001_0000, 32'h0001_0000, 4'h9);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0) chk("mul.busy_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      n++;
    end
    chk("mul.latency", 64'(n), 64'd32);
    chk_out("mul1", 32'd0, 1'b1, 1'b1, 4'h9);
    drive(4'hA, 32'd6, 32'd7, 4'h2);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("mul2.latency", 64'(n), 64'd32);
    chk_out("mul2", 32'd42, 1'b0, 1'b0, 4'h2);
    tick();

    // Reset 10 cycles into a multiply.
    drive(4'hA, 32'd3, 32'd5, 4'h4);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("midmul.out_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b1;
    #1;
    chk_reset("rst_mul");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid !== 1'b0) chk("rst_mul.no_ghost", {63'd0, out_valid}, 64'd0);
      tick();
    end
`endif

    drive(4'h1, 32'd100, 32'd1, 4'h1);
    #1;
    chk("post_rst.in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk_out("post_rst", 32'd99, 1'b0, 1'b0, 4'h1);
    tick();
    chk("post_rst.drain", {63'd0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
